name_feeder: RTL and testbench

Parametrised name sequencer that holds a table of NDN names and streams them, one full name per transfer, into the FIB lookup `top` over a valid/ready handshake. It replaces the free-running, saturating name counter with four additions: a loadable name table, a programmable name count, single-pass or loop mode, and back-pressure from the consumer. It sits between the load path (bench or host loader) and the `next_name_in` input of the lookup tree.

---
 rtl/ndn_fib_pkg.sv | 15 +
 rtl/name_store.sv | 34 +++
 rtl/name_feeder.sv | 129 ++++++++++++
 tb/tb_name_feeder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ndn_fib_pkg.sv
// Shared types and defaults for the NDN FIB lookup path and its name feeder.
package ndn_fib_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int MAX_NAME_LENGTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_t;

    typedef logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0] name_t;

endpackage

// File: rtl/name_store.sv
// Name table: NUM_NAMES x MAX_NAME_LENGTH words, one write port, full-name read.
module name_store
    import ndn_fib_pkg::*;
#(
    parameter int W_BITS    = WORD_SIZE,
    parameter int NAME_LEN  = MAX_NAME_LENGTH,
    parameter int NUM_NAMES = 9,
    parameter int IDX_W     = (NUM_NAMES > 1) ? $clog2(NUM_NAMES) : 1,
    parameter int WIDX_W    = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           wr_name_idx_i,
    input  logic [WIDX_W-1:0]          wr_word_idx_i,
    input  logic [W_BITS-1:0]          wr_data_i,
    input  logic [IDX_W-1:0]           rd_idx_i,
    output logic [NAME_LEN*W_BITS-1:0] rd_name_o
);

    localparam logic [IDX_W:0]  NAMES_LIM = (IDX_W+1)'(NUM_NAMES);
    localparam logic [WIDX_W:0] WORDS_LIM = (WIDX_W+1)'(NAME_LEN);

    // No reset: table contents are meant to survive rst_n.
    logic [NUM_NAMES-1:0][NAME_LEN-1:0][W_BITS-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (we_i && ({1'b0, wr_name_idx_i} < NAMES_LIM)
                 && ({1'b0, wr_word_idx_i} < WORDS_LIM))
            mem_q[wr_name_idx_i][wr_word_idx_i] <= wr_data_i;
    end

    assign rd_name_o = ({1'b0, rd_idx_i} < NAMES_LIM) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/name_feeder.sv
// Streams table names into the FIB lookup over valid/ready; single pass or loop.
module name_feeder
    import ndn_fib_pkg::*;
#(
    parameter int WORD_SIZE       = ndn_fib_pkg::WORD_SIZE,
    parameter int MAX_NAME_LENGTH = ndn_fib_pkg::MAX_NAME_LENGTH,
    parameter int NUM_NAMES       = 9,
    parameter int IDX_W           = (NUM_NAMES > 1) ? $clog2(NUM_NAMES) : 1,
    parameter int WIDX_W          = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [IDX_W-1:0]                     wr_name_idx,
    input  logic [WIDX_W-1:0]                    wr_word_idx,
    input  logic [WORD_SIZE-1:0]                 wr_data,
    input  logic                                 start,
    input  logic                                 loop_mode,
    input  logic [IDX_W:0]                       num_names,
    output logic                                 name_valid,
    input  logic                                 name_ready,
    output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_out,
    output logic [IDX_W-1:0]                     name_idx,
    output logic                                 busy,
    output logic                                 done,
    output logic [31:0]                          issued_count
);

    localparam logic [IDX_W:0] NAMES_MAX = (IDX_W+1)'(NUM_NAMES);

    feeder_state_t                        state_q, state_d;
    logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_q, name_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [31:0]                          cnt_q, cnt_d;
    logic [IDX_W:0]                       n_q, n_d;
    logic                                 loop_q, loop_d;

    logic [IDX_W-1:0]                     rd_idx;
    logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] rd_name;
    logic [IDX_W:0]                       n_eff;

    assign n_eff = (num_names > NAMES_MAX) ? NAMES_MAX : num_names;

    // The table is frozen while a pass is in flight.
    name_store #(
        .W_BITS   (WORD_SIZE),
        .NAME_LEN (MAX_NAME_LENGTH),
        .NUM_NAMES(NUM_NAMES),
        .IDX_W    (IDX_W),
        .WIDX_W   (WIDX_W)
    ) u_store (
        .clk          (clk),
        .we_i         (wr_en && (state_q != RUN)),
        .wr_name_idx_i(wr_name_idx),
        .wr_word_idx_i(wr_word_idx),
        .wr_data_i    (wr_data),
        .rd_idx_i     (rd_idx),
        .rd_name_o    (rd_name)
    );

    always_comb begin
        state_d = state_q;
        name_d  = name_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        loop_d  = loop_q;
        rd_idx  = '0;
        unique case (state_q)
            RUN: begin
                if (name_ready) begin
                    cnt_d = cnt_q + 32'd1;
                    if ({1'b0, idx_q} == n_q - 1'b1) begin
                        if (loop_q) begin
                            name_d = rd_name;
                            idx_d  = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        rd_idx = idx_q + 1'b1;
                        name_d = rd_name;
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    if (n_eff != '0) begin
                        state_d = RUN;
                        name_d  = rd_name;
                        idx_d   = '0;
                        cnt_d   = '0;
                        n_d     = n_eff;
                        loop_d  = loop_mode;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            name_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            name_q  <= name_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            loop_q  <= loop_d;
        end
    end

    assign name_valid   = (state_q == RUN);
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign name_out     = name_q;
    assign name_idx     = idx_q;
    assign issued_count = cnt_q;

endmodule

// File: tb/tb_name_feeder.sv
// Directed bench for name_feeder: single pass, back-pressure, loop, clamp, reset.
module tb_name_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [3:0]   wr_name_idx;
    logic [2:0]   wr_word_idx;
    logic [31:0]  wr_data;
    logic         start;
    logic         loop_mode;
    logic [4:0]   num_names;
    logic         name_valid;
    logic         name_ready;
    logic [255:0] name_out;
    logic [3:0]   name_idx;
    logic         busy;
    logic         done;
    logic [31:0]  issued_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] tbl [9][8];

    always #5 clk = ~clk;

    name_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_name_idx (wr_name_idx),
        .wr_word_idx (wr_word_idx),
        .wr_data     (wr_data),
        .start       (start),
        .loop_mode   (loop_mode),
        .num_names   (num_names),
        .name_valid  (name_valid),
        .name_ready  (name_ready),
        .name_out    (name_out),
        .name_idx    (name_idx),
        .busy        (busy),
        .done        (done),
        .issued_count(issued_count)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [255:0] exp_name(input int i);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = tbl[i][j];
        return r;
    endfunction

    task automatic wr(input int ni, input int wi, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_name_idx = 4'(ni); wr_word_idx = 3'(wi); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Leaves the bench at the negedge where slot 0 should be presented.
    task automatic do_start(input logic [4:0] n, input logic lp);
        @(negedge clk);
        num_names = n; loop_mode = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic single_pass(input string tag, input int n, input bit inject);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_vld"}, 256'(name_valid), 256'(1));
            chk({tag, "_idx"}, 256'(name_idx), 256'(i));
            chk({tag, "_name"}, name_out, exp_name(i));
            if (inject && i == 2) begin
                start = 1'b1; num_names = 5'd1; loop_mode = 1'b1;
                wr_en = 1'b1; wr_name_idx = 4'd5; wr_word_idx = 3'd0; wr_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 256'(done), 256'(1));
        chk({tag, "_vld_off"}, 256'(name_valid), 256'(0));
        chk({tag, "_busy_off"}, 256'(busy), 256'(0));
        chk({tag, "_cnt"}, 256'(issued_count), 256'(n));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_vld"}, 256'(name_valid), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
        chk({tag, "_name"}, name_out, 256'(0));
        chk({tag, "_idx"}, 256'(name_idx), 256'(0));
        chk({tag, "_cnt"}, 256'(issued_count), 256'(0));
    endtask

    initial begin
        int rdy_seq [6] = '{1, 0, 0, 1, 1, 1};
        int idx_seq [6] = '{0, 1, 1, 1, 2, 3};

        rst_n = 1'b0; wr_en = 1'b0; wr_name_idx = '0; wr_word_idx = '0; wr_data = '0;
        start = 1'b0; loop_mode = 1'b0; num_names = '0; name_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8; j++) begin
                tbl[i][j] = 32'((i << 8) | j);
                wr(i, j, tbl[i][j]);
            end
        // Out-of-range slot must not disturb anything.
        wr(12, 0, 32'h1234_5678);

        do_start(5'd9, 1'b0);
        single_pass("basic", 9, 1'b0);

        // Back-pressure: ready 1,0,0,1 then 1,1; N=4.
        do_start(5'd4, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("bp_vld", 256'(name_valid), 256'(1));
            chk("bp_idx", 256'(name_idx), 256'(idx_seq[k]));
            chk("bp_name", name_out, exp_name(idx_seq[k]));
            name_ready = rdy_seq[k][0];
            @(negedge clk);
        end
        chk("bp_done", 256'(done), 256'(1));
        chk("bp_cnt", 256'(issued_count), 256'(4));
        name_ready = 1'b1;

        // Zero count from DONE drops back to IDLE.
        do_start(5'd0, 1'b0);
        chk("zero_vld", 256'(name_valid), 256'(0));
        chk("zero_done", 256'(done), 256'(0));
        chk("zero_busy", 256'(busy), 256'(0));

        // Loop over 3 names for 10 transfers.
        do_start(5'd3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            chk("loop_idx", 256'(name_idx), 256'(k % 3));
            chk("loop_name", name_out, exp_name(k % 3));
            @(negedge clk);
        end
        chk("loop_cnt", 256'(issued_count), 256'(10));
        chk("loop_done", 256'(done), 256'(0));
        chk("loop_busy", 256'(busy), 256'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("loop_rst");
        rst_n = 1'b1;

        do_start(5'd12, 1'b0);
        single_pass("clamp", 9, 1'b0);

        // start and a slot-5 write mid-RUN are both ignored.
        do_start(5'd9, 1'b0);
        single_pass("ign", 9, 1'b1);
        loop_mode = 1'b0;
        wr(5, 0, 32'hCAFE_F00D);
        tbl[5][0] = 32'hCAFE_F00D;
        do_start(5'd9, 1'b0);
        single_pass("neww", 9, 1'b0);

        // Reset at idx 4, then a clean restart with the table intact.
        do_start(5'd9, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("mid_idx", 256'(name_idx), 256'(k));
            if (k < 4) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("mid_rst");
        rst_n = 1'b1;
        do_start(5'd9, 1'b0);
        single_pass("after", 9, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
